// File: rtl/dff_stream_deser_if.sv
// Stream bundle for dff_stream_deser: serial bit input and word valid/ready output.
// master = bit source / word consumer side, slave = the deserialiser.
interface dff_stream_deser_if #(
   parameter int WIDTH = 8
);
   logic             bit_in;
   logic             bit_vld;
   logic [WIDTH-1:0] word_out;
   logic             word_vld;
   logic             word_rdy;
   logic             sync_lock;
   logic             overflow;
   logic             parity_err;

   modport master (
      output bit_in, bit_vld, word_rdy,
      input  word_out, word_vld, sync_lock, overflow, parity_err
   );

   modport slave (
      input  bit_in, bit_vld, word_rdy,
      output word_out, word_vld, sync_lock, overflow, parity_err
   );
endinterface

// File: rtl/dff_stream_deser.sv
// Sync-word hunter and MSB-first deserialiser behind the dff sampling stage.
// Optional even-parity bit after each word: define PARITY_CHECK_EN.
module dff_stream_deser #(
   parameter int              WIDTH       = 8,
   parameter int              SYNC_W      = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT  = 'hA5,
   parameter int              FRAME_WORDS = 4
) (
   input logic                clk,
   input logic                rst_n,
   dff_stream_deser_if.slave  s
);

   typedef enum logic {
      HUNT    = 1'b0,
      COLLECT = 1'b1
   } state_t;

`ifdef PARITY_CHECK_EN
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam int              CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   LAST_C = CW'(LAST);
   localparam logic [7:0]      FEND   = 8'(FRAME_WORDS - 1);

   state_t            state_q, state_d;
   logic [SYNC_W-1:0] sync_sr_q, sync_sr_d;
   logic [WIDTH-1:0]  data_sr_q, data_sr_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]        word_cnt_q, word_cnt_d;
   logic [WIDTH-1:0]  word_out_q, word_out_d;
   logic              word_vld_q, word_vld_d;
   logic              sync_lock_q, sync_lock_d;
   logic              overflow_q, overflow_d;
   logic              parity_err_q, parity_err_d;

   logic [SYNC_W-1:0] sync_cand;
   logic [WIDTH-1:0]  word_w;
   logic              perr_w;
   logic              last_bit;
   logic              slot_free;

   // Candidate sync window, completed word and output-slot availability.
   always_comb begin
      sync_cand = {sync_sr_q[SYNC_W-2:0], s.bit_in};
      last_bit  = (bit_cnt_q == LAST_C);
      slot_free = !word_vld_q || s.word_rdy;
`ifdef PARITY_CHECK_EN
      // Data already sits in data_sr; the accepted bit is the parity bit.
      word_w    = data_sr_q;
      perr_w    = ^{data_sr_q, s.bit_in};
`else
      word_w    = {data_sr_q[WIDTH-2:0], s.bit_in};
      perr_w    = 1'b0;
`endif
   end

   // Next-state logic for the hunt/collect FSM, counters and output register.
   always_comb begin
      state_d      = state_q;
      sync_sr_d    = sync_sr_q;
      data_sr_d    = data_sr_q;
      bit_cnt_d    = bit_cnt_q;
      word_cnt_d   = word_cnt_q;
      word_out_d   = word_out_q;
      word_vld_d   = word_vld_q;
      sync_lock_d  = sync_lock_q;
      overflow_d   = overflow_q;
      parity_err_d = 1'b0;

      if (word_vld_q && s.word_rdy) begin
         word_vld_d = 1'b0;
      end

      if (s.bit_vld) begin
         unique case (state_q)
            HUNT: begin
               sync_sr_d = sync_cand;
               if (sync_cand == SYNC_PAT) begin
                  state_d     = COLLECT;
                  bit_cnt_d   = '0;
                  word_cnt_d  = '0;
                  sync_lock_d = 1'b1;
               end
            end
            COLLECT: begin
               if (last_bit) begin
                  // A full slot drops the word but frame timing carries on.
                  if (slot_free) begin
                     word_out_d = word_w;
                     word_vld_d = 1'b1;
                  end else begin
                     overflow_d = 1'b1;
                  end
                  parity_err_d = perr_w;
                  bit_cnt_d    = '0;
                  if (word_cnt_q == FEND) begin
                     state_d     = HUNT;
                     sync_lock_d = 1'b0;
                     sync_sr_d   = '0;
                     word_cnt_d  = '0;
                  end else begin
                     word_cnt_d = word_cnt_q + 8'd1;
                  end
               end else begin
                  data_sr_d = {data_sr_q[WIDTH-2:0], s.bit_in};
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

   // State and registered outputs; reset discards any partial word or frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         sync_sr_q    <= '0;
         data_sr_q    <= '0;
         bit_cnt_q    <= '0;
         word_cnt_q   <= '0;
         word_out_q   <= '0;
         word_vld_q   <= 1'b0;
         sync_lock_q  <= 1'b0;
         overflow_q   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_sr_q    <= sync_sr_d;
         data_sr_q    <= data_sr_d;
         bit_cnt_q    <= bit_cnt_d;
         word_cnt_q   <= word_cnt_d;
         word_out_q   <= word_out_d;
         word_vld_q   <= word_vld_d;
         sync_lock_q  <= sync_lock_d;
         overflow_q   <= overflow_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign s.word_out   = word_out_q;
   assign s.word_vld   = word_vld_q;
   assign s.sync_lock  = sync_lock_q;
   assign s.overflow   = overflow_q;
   assign s.parity_err = parity_err_q;

endmodule

// File: tb/tb_dff_stream_deser.sv
// Scoreboard bench for dff_stream_deser: directed streams, queued expected words.
// Build with PARITY_CHECK_EN defined to exercise the parity path.
module tb_dff_stream_deser;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dff_stream_deser_if #(.WIDTH(8)) bus ();

   dff_stream_deser #(
      .WIDTH(8),
      .SYNC_W(8),
      .SYNC_PAT(8'hA5),
      .FRAME_WORDS(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .s(bus)
   );

   int         checks = 0;
   int         failures = 0;
   int         handshakes = 0;
   int         hs0;
   bit         gap = 1'b0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_w;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted word is popped from the scoreboard and compared.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && bus.word_vld && bus.word_rdy) begin
            handshakes++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_word: got %0h expected none",
                        bus.word_out);
            end else begin
               exp_w = exp_q.pop_front();
               if (bus.word_out !== exp_w) begin
                  failures++;
                  $display("FAIL word: got %0h expected %0h",
                           bus.word_out, exp_w);
               end
            end
         end
      end
   end

   task automatic send_bit(input logic b);
      if (gap) begin
         @(negedge clk);
         bus.bit_in  = ~b;
         bus.bit_vld = 1'b0;
      end
      @(negedge clk);
      bus.bit_in  = b;
      bus.bit_vld = 1'b1;
   endtask

   task automatic send_word(input logic [7:0] w, input bit push,
                            input bit bad_par);
      if (push) exp_q.push_back(w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef PARITY_CHECK_EN
      send_bit((^w) ^ bad_par);
`else
      if (bad_par) $display("note: parity bit not in stream");
`endif
   endtask

   task automatic idle();
      @(negedge clk);
      bus.bit_vld = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.bit_vld = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.bit_in   = 1'b0;
      bus.bit_vld  = 1'b0;
      bus.word_rdy = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_word_out", bus.word_out, 0);
      chk("rst_word_vld", bus.word_vld, 0);
      chk("rst_sync_lock", bus.sync_lock, 0);
      chk("rst_overflow", bus.overflow, 0);
      chk("rst_parity_err", bus.parity_err, 0);
      rst_n = 1'b1;

      // Test 1: asynchronous reset mid-word, then a clean frame start
      send_word(8'hA5, 0, 0);
      for (int i = 7; i >= 3; i--) send_bit(1'b1);
      @(posedge clk);
      #2;
      chk("t1_lock_before_rst", bus.sync_lock, 1);
      rst_n = 1'b0;
      #1;
      chk("t1_async_lock", bus.sync_lock, 0);
      chk("t1_async_vld", bus.word_vld, 0);
      @(negedge clk);
      bus.bit_vld = 1'b0;
      rst_n = 1'b1;
      send_word(8'hA5, 0, 0);
      send_word(8'h3C, 1, 0);
      idle();
      chk("t1_word_out", bus.word_out, 8'h3C);
      idle();

      // Test 2: leading junk, lock timing and one-cycle word latency
      do_reset();
      send_word(8'hFF, 0, 0);
      chk("t2_no_lock_ff", bus.sync_lock, 0);
      send_word(8'hA5, 0, 0);
      chk("t2_lock_not_yet", bus.sync_lock, 0);
      idle();
      chk("t2_lock", bus.sync_lock, 1);
      send_word(8'h3C, 1, 0);
      chk("t2_vld_not_yet", bus.word_vld, 0);
      idle();
      chk("t2_vld", bus.word_vld, 1);
      chk("t2_word_out", bus.word_out, 8'h3C);
      chk("t2_parity_err", bus.parity_err, 0);
      idle();
      chk("t2_vld_drop", bus.word_vld, 0);

      // Test 3: backpressure holds first word, second is dropped
      do_reset();
      bus.word_rdy = 1'b0;
      send_word(8'hA5, 0, 0);
      send_word(8'h11, 1, 0);
      send_word(8'h22, 0, 0);
      idle();
      chk("t3_overflow", bus.overflow, 1);
      chk("t3_word_out", bus.word_out, 8'h11);
      chk("t3_vld", bus.word_vld, 1);
      hs0 = handshakes;
      @(negedge clk);
      bus.word_rdy = 1'b1;
      idle();
      idle();
      chk("t3_vld_after", bus.word_vld, 0);
      chk("t3_once", handshakes - hs0, 1);
      chk("t3_sticky", bus.overflow, 1);

      // Test 4: frame end returns to hunting, trailing sync re-locks
      do_reset();
      hs0 = handshakes;
      send_word(8'hA5, 0, 0);
      send_word(8'h01, 1, 0);
      send_word(8'h02, 1, 0);
      send_word(8'h03, 1, 0);
      chk("t4_lock_mid", bus.sync_lock, 1);
      send_word(8'h04, 1, 0);
      idle();
      chk("t4_unlock", bus.sync_lock, 0);
      chk("t4_last_word", bus.word_out, 8'h04);
      send_word(8'hA5, 0, 0);
      idle();
      chk("t4_relock", bus.sync_lock, 1);
      idle();
      chk("t4_count", handshakes - hs0, 4);

      // Test 5: bit_vld every other cycle, same result as test 2
      do_reset();
      gap = 1'b1;
      hs0 = handshakes;
      send_word(8'hFF, 0, 0);
      send_word(8'hA5, 0, 0);
      idle();
      chk("t5_lock", bus.sync_lock, 1);
      send_word(8'h3C, 1, 0);
      idle();
      chk("t5_vld", bus.word_vld, 1);
      chk("t5_word_out", bus.word_out, 8'h3C);
      repeat (4) idle();
      chk("t5_count", handshakes - hs0, 1);
      gap = 1'b0;

`ifdef PARITY_CHECK_EN
      // Test 6: parity mismatch pulses exactly with word_vld rise
      do_reset();
      send_word(8'hA5, 0, 0);
      send_word(8'h3C, 1, 1);
      idle();
      chk("t6_perr_pulse", bus.parity_err, 1);
      chk("t6_word_out", bus.word_out, 8'h3C);
      idle();
      chk("t6_perr_clear", bus.parity_err, 0);
      send_word(8'h3C, 1, 0);
      idle();
      chk("t6_good_vld", bus.word_vld, 1);
      chk("t6_good_noperr", bus.parity_err, 0);
      idle();
`endif

      repeat (3) idle();
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
